mux_2x1_arbiter: RTL and testbench
==================================

Name: mux_2x1_arbiter

Overview:
Round-robin arbiter that shares one 2:1 mux output path between two requesters. It registers the mux select and the one-hot grants, and moves data to a single downstream consumer over a valid/ready handshake. A burst limit keeps one requester from holding the path indefinitely. Sits directly in front of the shared output path; the select it produces is the only control of the mux.

Parameters:
WIDTH, 8, data width of each input and of the output
MAX_BURST, 4, maximum consecutive transfers per grant while the other requester is waiting (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  2  req[i] high = requester i has data; must stay high until its transfer completes
in0  input  WIDTH  requester 0 data
in1  input  WIDTH  requester 1 data
gnt  output  2  one-hot registered grant; 2'b00 when idle
sel  output  1  registered mux select (0 = in0, 1 = in1)
out_data  output  WIDTH  sel ? in1 : in0 (combinational)
out_valid  output  1  gnt[sel] & req[sel] (combinational)
out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset values: state=IDLE, gnt=2'b00, sel=0, burst count cnt=0, last-granted register last=1 (port 0 wins the first contention). out_valid is therefore 0 during reset.
- Transfer: occurs on a rising edge where out_valid & out_ready = 1.
- cnt: counts transfers in the current grant, width ceil(log2(MAX_BURST))+1. It is cleared on every grant change and on entry to IDLE.
- IDLE:
  - req=00: stay in IDLE.
  - Exactly one req high: go to GRANTi for that requester.
  - req=11: go to GRANTi with i = ~last.
  - On entry to GRANTi: gnt=onehot(i), sel=i, last=i.
  - Latency: req sampled high in cycle n -> gnt high in cycle n+1. The first transfer can happen in cycle n+1.
- GRANTi, evaluated each edge in this order:
  1. req[i]=0 (release, with or without a transfer): if req[~i]=1, go directly to GRANT~i (no idle bubble); otherwise go to IDLE (gnt=00, sel holds its value).
  2. Transfer and cnt==MAX_BURST-1:
     - req[~i]=1: go to GRANT~i, cnt=0.
     - req[~i]=0: stay in GRANTi, cnt=0 (unlimited burst when there is no contention).
  3. Transfer otherwise: cnt=cnt+1, stay in GRANTi.
  4. No transfer (out_ready=0): hold state, cnt, gnt and sel. A stalled grant is never revoked.
- gnt and sel change only on clock edges. gnt is never 2'b11. sel always equals the index of the active grant while gnt!=00.
- out_data follows the in0/in1 inputs combinationally. The requester must hold its data stable while out_valid & !out_ready.
- Simultaneous release of the current grant and a new request from the other side: the rule-1 switch applies.
- Reset asserted mid-burst: immediate return to the reset values. Any transfer in flight is dropped and is not replayed.

Test Plan:
- Reset: rst_n=0 with req=11 -> gnt=00, sel=0, out_valid=0. Release rst_n -> gnt=01 one edge later; out_data=in0.
- Single requester: req=10, in1=8'hA5, out_ready=1 held for 10 cycles -> gnt=10, sel=1 continuously, 10 transfers of A5, no forced rotation.
- Burst limit: req=11, out_ready=1, MAX_BURST=4 -> grants alternate in blocks of exactly 4 transfers (port 0 first): 01×4, 10×4, 01×4.
- Backpressure: grant to port 0, out_ready=0 for 5 cycles with req=11 -> gnt stays 01, cnt unchanged, out_valid=1. Then out_ready=1 -> burst completes with 4 transfers total.
- Release switch: port 0 granted, req goes from 11 to 10 -> the next edge gives gnt=10, sel=1 with no idle cycle. req goes to 00 -> gnt=00, sel stays 1, out_valid=0.
- Async reset mid-burst: assert rst_n low between clock edges after 2 of 4 transfers -> gnt=00 immediately, without waiting for a clock edge. After release with req=11 -> port 0 granted (last reset to 1) and cnt restarts at 0.

Source files
------------

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux path.
// Registered one-hot grant and select, valid/ready output, burst-limited grants.
module mux_2x1_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [1:0]       gnt,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned     CW       = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            last, last_nxt;
   logic            sel_nxt;
   logic [1:0]      gnt_nxt;
   logic            xfer;
   logic            cur;
   logic            do_grant;
   logic            grant_idx;

   assign out_data  = sel ? in1 : in0;
   assign out_valid = gnt[sel] & req[sel];
   assign xfer      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 2'b00;
         sel   <= 1'b0;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      sel_nxt   = sel;
      do_grant  = 1'b0;
      grant_idx = 1'b0;
      cur       = (state == GRANT1);

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (req == 2'b11) begin
               do_grant  = 1'b1;
               grant_idx = ~last;
            end else if (req[0]) begin
               do_grant  = 1'b1;
               grant_idx = 1'b0;
            end else if (req[1]) begin
               do_grant  = 1'b1;
               grant_idx = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            // Release takes priority over the burst check; with no transfer everything holds
            if (!req[cur]) begin
               if (req[~cur]) begin
                  do_grant  = 1'b1;
                  grant_idx = ~cur;
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else if (xfer) begin
               if (cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  if (req[~cur]) begin
                     do_grant  = 1'b1;
                     grant_idx = ~cur;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (do_grant) begin
         state_nxt = grant_idx ? GRANT1 : GRANT0;
         sel_nxt   = grant_idx;
         last_nxt  = grant_idx;
         cnt_nxt   = '0;
      end

      unique case (state_nxt)
         GRANT0:  gnt_nxt = 2'b01;
         GRANT1:  gnt_nxt = 2'b10;
         default: gnt_nxt = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Self-checking bench for mux_2x1_arbiter: directed scenarios plus random traffic
// against a behavioural owner/count model.
module tb_mux_2x1_arbiter;

   localparam int W  = 8;
   localparam int MB = 4;

   logic         clk;
   logic         rst_n;
   logic [1:0]   req;
   logic [W-1:0] in0;
   logic [W-1:0] in1;
   logic [1:0]   gnt;
   logic         sel;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   int checks;
   int errors;

   // reference model: owner -1 = idle
   int   own;
   int   mlast;
   int   mcnt;
   logic msel;

   int xfers [2];

   mux_2x1_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in0       (in0),
      .in1       (in1),
      .gnt       (gnt),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      own   = -1;
      mlast = 1;
      mcnt  = 0;
      msel  = 1'b0;
   endtask

   task automatic model_grant(input int i);
      own   = i;
      mlast = i;
      mcnt  = 0;
      msel  = (i == 1);
   endtask

   task automatic model_edge(input logic [1:0] r, input logic rdy);
      int  o;
      bit  moved;
      moved = 0;
      if (own < 0) begin
         if (r == 2'b11)     model_grant(1 - mlast);
         else if (r[0])      model_grant(0);
         else if (r[1])      model_grant(1);
      end else begin
         o = 1 - own;
         if (!r[own]) begin
            if (r[o]) model_grant(o);
            else begin
               own  = -1;
               mcnt = 0;
            end
         end else if (rdy) begin
            mcnt = mcnt + 1;
            if (mcnt == MB) begin
               mcnt = 0;
               if (r[o]) moved = 1;
            end
            if (moved) model_grant(o);
         end
      end
   endtask

   task automatic compare_all(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [1:0] eg;
      logic       ev;
      eg = (own < 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
      ev = 1'b0;
      if (own >= 0) ev = r[own];
      chk("gnt",       32'(gnt),       32'(eg));
      chk("sel",       32'(sel),       32'(msel));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_data",  32'(out_data),  32'(msel ? b : a));
   endtask

   // drive inputs just after an edge, check before the next, then advance the model
   task automatic cycle(input logic [1:0] r, input logic rdy, input logic [W-1:0] a, input logic [W-1:0] b);
      req       = r;
      out_ready = rdy;
      in0       = a;
      in1       = b;
      #1;
      compare_all(r, a, b);
      if (out_valid && out_ready) xfers[sel] = xfers[sel] + 1;
      @(posedge clk);
      model_edge(r, rdy);
      #1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      xfers[0] = 0;
      xfers[1] = 0;
      model_reset();

      // reset with both requesting
      rst_n     = 1'b0;
      req       = 2'b11;
      in0       = 8'h3C;
      in1       = 8'hC3;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",   32'(gnt),       32'(2'b00));
      chk("rst_sel",   32'(sel),       32'(1'b0));
      chk("rst_valid", 32'(out_valid), 32'(1'b0));
      rst_n = 1'b1;

      // first grant goes to port 0, then backpressure holds it
      cycle(2'b11, 1'b0, 8'h3C, 8'hC3);
      chk("first_gnt",  32'(gnt),      32'(2'b01));
      chk("first_data", 32'(out_data), 32'(8'h3C));
      repeat (5) cycle(2'b11, 1'b0, 8'h11, 8'h22);
      chk("stall_gnt",   32'(gnt),       32'(2'b01));
      chk("stall_valid", 32'(out_valid), 32'(1'b1));
      chk("stall_xfers", 32'(xfers[0]),  32'(0));

      // burst limit: blocks of four alternating
      repeat (4) cycle(2'b11, 1'b1, 8'h11, 8'h22);
      chk("burst0_xfers", 32'(xfers[0]), 32'(4));
      chk("burst0_gnt",   32'(gnt),      32'(2'b10));
      repeat (4) cycle(2'b11, 1'b1, 8'h33, 8'h44);
      chk("burst1_xfers", 32'(xfers[1]), 32'(4));
      chk("burst1_gnt",   32'(gnt),      32'(2'b01));

      // release switch without an idle bubble
      cycle(2'b11, 1'b1, 8'h55, 8'h66);
      cycle(2'b10, 1'b1, 8'h55, 8'h66);
      chk("switch_gnt", 32'(gnt), 32'(2'b10));
      chk("switch_sel", 32'(sel), 32'(1'b1));
      cycle(2'b00, 1'b1, 8'h55, 8'h66);
      chk("idle_gnt", 32'(gnt), 32'(2'b00));
      chk("idle_sel", 32'(sel), 32'(1'b1));
      cycle(2'b00, 1'b1, 8'h55, 8'h66);

      // single requester is never rotated away
      xfers[1] = 0;
      repeat (11) cycle(2'b10, 1'b1, 8'h00, 8'hA5);
      chk("single_xfers", 32'(xfers[1]), 32'(10));
      chk("single_gnt",   32'(gnt),      32'(2'b10));
      cycle(2'b00, 1'b1, 8'h00, 8'hA5);

      // async reset after two transfers of a burst
      cycle(2'b11, 1'b1, 8'h77, 8'h88);
      chk("pre_rst_gnt", 32'(gnt), 32'(2'b01));
      cycle(2'b11, 1'b1, 8'h77, 8'h88);
      cycle(2'b11, 1'b1, 8'h77, 8'h88);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_gnt",   32'(gnt),       32'(2'b00));
      chk("async_sel",   32'(sel),       32'(1'b0));
      chk("async_valid", 32'(out_valid), 32'(1'b0));
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      xfers[0] = 0;
      cycle(2'b11, 1'b1, 8'h99, 8'hAA);
      chk("post_rst_gnt", 32'(gnt), 32'(2'b01));
      repeat (4) cycle(2'b11, 1'b1, 8'h99, 8'hAA);
      chk("post_rst_xfers", 32'(xfers[0]), 32'(4));
      chk("post_rst_rot",   32'(gnt),      32'(2'b10));

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         cycle(2'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
